// File: rtl/onfi_reg_bank.sv
// onfi_reg_bank: Wishbone register bank issuing per-channel ONFI commands and collecting status
module onfi_reg_bank #(
  parameter int          MM_DATA_W = 32,
  parameter int          MM_ADDR_W = 8,
  parameter int          N_CH      = 2,
  parameter logic [31:0] ID_VALUE  = 32'hdeaddead
) (
  input  logic                   mm_clk_i,
  input  logic                   mm_rst_i,
  input  logic                   mm_cyc_i,
  input  logic                   mm_stb_i,
  input  logic                   mm_we_i,
  input  logic [MM_ADDR_W-1:0]   mm_addr_i,
  input  logic [MM_DATA_W/8-1:0] mm_sel_i,
  input  logic [MM_DATA_W-1:0]   mm_dat_i,
  output logic [MM_DATA_W-1:0]   mm_dat_o,
  output logic                   mm_ack_o,
  output logic                   mm_err_o,
  output logic [N_CH-1:0]        cmd_valid_o,
  input  logic [N_CH-1:0]        cmd_ready_i,
  output logic [32*N_CH-1:0]     cmd_word_o,
  output logic [32*N_CH-1:0]     cmd_addr_o,
  input  logic [N_CH-1:0]        done_i,
  input  logic [N_CH-1:0]        fail_i,
  output logic                   irq_o
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int PW = MM_ADDR_W - 4;
  typedef enum logic {S_IDLE, S_RESP} state_t;
  state_t                 r_state;
  logic                   r_ack, r_err, r_irq;
  logic [MM_DATA_W-1:0]   r_dat;
  logic [31:0]            r_scratch;
  logic [31:0]            r_cmd  [N_CH];
  logic [31:0]            r_addr [N_CH];
  logic [31:0]            r_snap [N_CH];
  logic [N_CH-1:0]        r_busy, r_done, r_fail;
  logic                   w_req, w_is_id, w_is_scr, w_is_ch, w_is_cmd, w_is_sts, w_is_adr, w_bad, w_wr;
  logic                   w_unused;
  logic [PW-1:0]          w_page;
  logic [1:0]             w_off;
  logic [CW-1:0]          w_ch;
  logic [31:0]            w_mask, w_rdata;
  logic [N_CH-1:0]        w_chv, w_wcmd, w_wadr, w_go, w_clr_d, w_clr_f, w_irq_en;
  assign w_unused = ^mm_addr_i[1:0];
  assign w_req    = r_state == S_IDLE && mm_cyc_i && mm_stb_i;
  // Page 0 holds ID/SCRATCH; page p>0 is channel p-1 with CMD/STATUS/ADDR in its first three words.
  assign w_page   = mm_addr_i[MM_ADDR_W-1:4];
  assign w_off    = mm_addr_i[3:2];
  assign w_ch     = CW'(w_page - PW'(1));
  assign w_is_ch  = w_page != '0 && w_page <= PW'(N_CH);
  assign w_is_id  = w_page == '0 && w_off == 2'd0;
  assign w_is_scr = w_page == '0 && w_off == 2'd1;
  assign w_is_cmd = w_is_ch && w_off == 2'd0;
  assign w_is_sts = w_is_ch && w_off == 2'd1;
  assign w_is_adr = w_is_ch && w_off == 2'd2;
  assign w_bad    = !(w_is_id || w_is_scr || w_is_cmd || w_is_sts || w_is_adr) ||
                    (mm_we_i && (w_is_id || (w_is_cmd && r_busy[w_ch])));
  assign w_wr     = w_req && mm_we_i && !w_bad;
  assign w_mask   = {{8{mm_sel_i[3]}}, {8{mm_sel_i[2]}}, {8{mm_sel_i[1]}}, {8{mm_sel_i[0]}}};
  assign w_chv    = w_is_ch ? N_CH'(1) << w_ch : '0;
  assign w_wcmd   = {N_CH{w_wr && w_is_cmd}} & w_chv;
  assign w_wadr   = {N_CH{w_wr && w_is_adr}} & w_chv;
  assign w_go     = w_wcmd & {N_CH{mm_sel_i[0] & mm_dat_i[0]}};
  assign w_clr_d  = {N_CH{w_wr && w_is_sts && mm_sel_i[0] && mm_dat_i[0]}} & w_chv;
  assign w_clr_f  = {N_CH{w_wr && w_is_sts && mm_sel_i[0] && mm_dat_i[1]}} & w_chv;
  assign w_rdata  = w_is_id  ? ID_VALUE :
                    w_is_scr ? r_scratch :
                    w_is_cmd ? r_cmd[w_ch] :
                    w_is_sts ? {r_busy[w_ch], 29'b0, r_fail[w_ch], r_done[w_ch]} :
                    w_is_adr ? r_addr[w_ch] : 32'h0;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign cmd_word_o[32*c +: 32] = r_cmd[c];
    assign cmd_addr_o[32*c +: 32] = r_busy[c] ? r_snap[c] : r_addr[c];
    assign w_irq_en[c]            = r_cmd[c][1];
  end
  assign cmd_valid_o = r_busy;
  assign mm_ack_o    = r_ack;
  assign mm_err_o    = r_err;
  assign mm_dat_o    = r_dat;
  assign irq_o       = r_irq;
  // Bus FSM with registered response, register commits, command handshake and sticky status.
  always_ff @(posedge mm_clk_i) begin
    if (mm_rst_i) begin
      r_state   <= S_IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_irq     <= 1'b0;
      r_scratch <= '0;
      r_busy    <= '0;
      r_done    <= '0;
      r_fail    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_cmd[c]  <= '0;
        r_addr[c] <= '0;
        r_snap[c] <= '0;
      end
    end else begin
      r_state <= w_req ? S_RESP : S_IDLE;
      r_ack   <= w_req && !w_bad;
      r_err   <= w_req && w_bad;
      r_dat   <= (w_req && !mm_we_i && !w_bad) ? w_rdata : '0;
      if (w_wr && w_is_scr) r_scratch <= (r_scratch & ~w_mask) | (mm_dat_i & w_mask);
      r_busy <= w_go | (r_busy & ~cmd_ready_i);
      r_done <= (r_done & ~w_clr_d) | done_i;
      r_fail <= (r_fail & ~w_clr_f) | fail_i;
      r_irq  <= |(w_irq_en & (r_done | r_fail));
      for (int c = 0; c < N_CH; c++) begin
        if (w_wcmd[c]) r_cmd[c] <= ((r_cmd[c] & ~w_mask) | (mm_dat_i & w_mask)) & ~32'd1;
        if (w_wadr[c]) r_addr[c] <= (r_addr[c] & ~w_mask) | (mm_dat_i & w_mask);
        if (w_go[c]) r_snap[c] <= r_addr[c];
      end
    end
  end
endmodule

// File: tb/tb_onfi_reg_bank.sv
// tb_onfi_reg_bank: scoreboard bench for the ONFI register bank
module tb_onfi_reg_bank;
  typedef struct packed {logic ack; logic err; logic [31:0] dat;} rsp_t;
  logic         clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [7:0]   addr = '0;
  logic [3:0]   sel = '0;
  logic [31:0]  wdat = '0, rdat, rdat4;
  logic         ack, err, irq, ack4, err4, irq4;
  logic [1:0]   vld, rdy = '0, dn = '0, fl = '0;
  logic [3:0]   vld4;
  logic [63:0]  word, cadr;
  logic [127:0] word4, cadr4;
  rsp_t         exp_q[$];
  rsp_t         mon_e;
  int           n_vec = 0, n_bad = 0, n_ack4 = 0;

  always #5 clk = ~clk;

  onfi_reg_bank dut (
    .mm_clk_i(clk), .mm_rst_i(rst), .mm_cyc_i(cyc), .mm_stb_i(stb), .mm_we_i(we),
    .mm_addr_i(addr), .mm_sel_i(sel), .mm_dat_i(wdat), .mm_dat_o(rdat),
    .mm_ack_o(ack), .mm_err_o(err), .cmd_valid_o(vld), .cmd_ready_i(rdy),
    .cmd_word_o(word), .cmd_addr_o(cadr), .done_i(dn), .fail_i(fl), .irq_o(irq)
  );

  onfi_reg_bank #(.N_CH(4)) u4 (
    .mm_clk_i(clk), .mm_rst_i(rst), .mm_cyc_i(cyc), .mm_stb_i(stb), .mm_we_i(we),
    .mm_addr_i(addr), .mm_sel_i(sel), .mm_dat_i(wdat), .mm_dat_o(rdat4),
    .mm_ack_o(ack4), .mm_err_o(err4), .cmd_valid_o(vld4), .cmd_ready_i(4'hF),
    .cmd_word_o(word4), .cmd_addr_o(cadr4), .done_i(4'h0), .fail_i(4'h0), .irq_o(irq4)
  );

  // scoreboard: every bus response pops the next expected response
  always @(negedge clk) begin
    if (ack || err) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bus_unexpected addr=%h got ack=%0b err=%0b dat=%h", addr, ack, err, rdat);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ack, err, rdat} !== mon_e) begin
          n_bad++;
          $display("FAIL bus_rsp addr=%h got ack=%0b err=%0b dat=%h exp ack=%0b err=%0b dat=%h",
                   addr, ack, err, rdat, mon_e.ack, mon_e.err, mon_e.dat);
        end
      end
    end
    if (ack4) n_ack4++;
  end

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic xfer(input logic w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    int k;
    @(posedge clk) #1;
    cyc = 1; stb = 1; we = w; addr = a; sel = s; wdat = d;
    @(posedge clk) #1;
    cyc = 0; stb = 0; we = 0;
    k = 0;
    while (!(ack || err) && k < 4) begin
      @(posedge clk) #1;
      k++;
    end
    n_vec++;
    if (k != 0) begin
      n_bad++;
      $display("FAIL bus_latency addr=%h got %0d cycles exp 1", a, k + 1);
      if (!(ack || err) && exp_q.size() != 0) exp_q.delete(0);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d, input logic e);
    exp_q.push_back('{!e, e, 32'h0});
    xfer(1'b1, a, s, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] x, input logic e);
    exp_q.push_back('{!e, e, e ? 32'h0 : x});
    xfer(1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({ack, err, rdat, vld, irq} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctl got ack=%0b err=%0b dat=%h vld=%b irq=%0b exp all 0", ack, err, rdat, vld, irq);
    end
    n_vec++;
    if ({word, cadr} !== '0) begin
      n_bad++;
      $display("FAIL reset_cmd got word=%h addr=%h exp 0", word, cadr);
    end
    @(posedge clk) #1;
    rst = 0;
  endtask

  task automatic test_id();
    rd(8'h00, 32'hdeaddead, 0);
    wr(8'h00, 4'hF, 32'h12345678, 1);
    rd(8'h00, 32'hdeaddead, 0);
  endtask

  task automatic test_scratch();
    logic [31:0] m;
    m = 32'h0;
    rd(8'h04, m, 0);
    wr(8'h04, 4'b0101, 32'hA5A5A5A5, 0);
    rd(8'h04, 32'h00A500A5, 0);
    m = 32'h00A500A5;
    wr(8'h04, 4'b1010, 32'h12345678, 0);
    m = (m & ~bmask(4'b1010)) | (32'h12345678 & bmask(4'b1010));
    rd(8'h04, m, 0);
    wr(8'h04, 4'b0000, 32'hFFFFFFFF, 0);
    rd(8'h04, m, 0);
  endtask

  task automatic test_unmapped();
    rd(8'h08, 32'h0, 1);
    rd(8'h0C, 32'h0, 1);
    rd(8'h1C, 32'h0, 1);
    wr(8'h2C, 4'hF, 32'h1, 1);
    rd(8'h30, 32'h0, 1);
    wr(8'h30, 4'hF, 32'h1, 1);
    rd(8'hF0, 32'h0, 1);
  endtask

  task automatic test_nch4();
    int c0;
    c0 = n_ack4;
    rd(8'h30, 32'h0, 1);
    #1;
    n_vec++;
    if (n_ack4 - c0 != 1) begin
      n_bad++;
      $display("FAIL nch4_ack got %0d acks exp 1", n_ack4 - c0);
    end
  endtask

  task automatic test_cmd_handshake();
    int vc;
    vc = 0;
    rdy = '0;
    wr(8'h10, 4'hF, 32'h00000005, 0);
    for (int i = 0; i < 6; i++) begin
      if (vld[0]) begin
        vc++;
        n_vec++;
        if (word[31:0] !== 32'h4) begin
          n_bad++;
          $display("FAIL cmd_word cyc=%0d got %h exp 00000004", i, word[31:0]);
        end
      end
      @(posedge clk) #1;
      rdy[0] = (i == 2);
      @(negedge clk);
    end
    n_vec++;
    if (vc != 4 || vld !== 2'b00) begin
      n_bad++;
      $display("FAIL cmd_valid_len got %0d cycles vld=%b exp 4 cycles vld=00", vc, vld);
    end
    rd(8'h10, 32'h4, 0);
    rd(8'h14, 32'h0, 0);
  endtask

  task automatic test_cmd_busy();
    rdy = '0;
    wr(8'h18, 4'hF, 32'h11110000, 0);
    wr(8'h10, 4'hF, 32'h00000009, 0);
    n_vec++;
    if (vld !== 2'b01 || cadr[31:0] !== 32'h11110000) begin
      n_bad++;
      $display("FAIL busy_start got vld=%b addr=%h exp vld=01 addr=11110000", vld, cadr[31:0]);
    end
    rd(8'h14, 32'h80000000, 0);
    wr(8'h10, 4'hF, 32'h00000001, 1);
    rd(8'h10, 32'h8, 0);
    wr(8'h18, 4'hF, 32'h22220000, 0);
    n_vec++;
    if (vld[0] !== 1'b1 || cadr[31:0] !== 32'h11110000 || word[31:0] !== 32'h8) begin
      n_bad++;
      $display("FAIL busy_stable got vld=%b addr=%h word=%h exp vld=1 addr=11110000 word=8", vld[0], cadr[31:0], word[31:0]);
    end
    @(posedge clk) #1;
    rdy[0] = 1;
    @(posedge clk) #1;
    rdy[0] = 0;
    @(negedge clk);
    n_vec++;
    if (vld !== 2'b00 || cadr[31:0] !== 32'h22220000) begin
      n_bad++;
      $display("FAIL busy_end got vld=%b addr=%h exp vld=00 addr=22220000", vld, cadr[31:0]);
    end
    rd(8'h14, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] m;
    wr(8'h28, 4'hF, 32'hCAFEF00D, 0);
    m = (32'hCAFEF00D & ~bmask(4'b1100)) | (32'h12345678 & bmask(4'b1100));
    wr(8'h28, 4'b1100, 32'h12345678, 0);
    rd(8'h28, m, 0);
    rd(8'h18, 32'h22220000, 0);
    rd(8'h20, 32'h0, 0);
    n_vec++;
    if (cadr[63:32] !== m) begin
      n_bad++;
      $display("FAIL cmd_addr1 got %h exp %h", cadr[63:32], m);
    end
  endtask

  task automatic test_irq();
    wr(8'h20, 4'hF, 32'h2, 0);
    rd(8'h24, 32'h0, 0);
    @(posedge clk) #1;
    fl = 2'b10;
    @(posedge clk) #1;
    fl = 2'b00;
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_latency got %0b exp 0", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_set got %0b exp 1", irq);
    end
    rd(8'h24, 32'h2, 0);
    wr(8'h24, 4'h1, 32'h2, 0);
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_clr_latency got %0b exp 1", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_clr got %0b exp 0", irq);
    end
    rd(8'h24, 32'h0, 0);
    @(posedge clk) #1;
    dn = 2'b10;
    @(posedge clk) #1;
    dn = 2'b00;
    rd(8'h24, 32'h1, 0);
    exp_q.push_back('{1'b1, 1'b0, 32'h0});
    @(posedge clk) #1;
    cyc = 1; stb = 1; we = 1; addr = 8'h24; sel = 4'h1; wdat = 32'h1; dn = 2'b10;
    @(posedge clk) #1;
    cyc = 0; stb = 0; we = 0; dn = 2'b00;
    @(negedge clk);
    rd(8'h24, 32'h1, 0);
    n_vec++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_collide got %0b exp 1", irq);
    end
    wr(8'h24, 4'h1, 32'h1, 0);
    rd(8'h24, 32'h0, 0);
    n_vec++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_done_clr got %0b exp 0", irq);
    end
  endtask

  task automatic test_reset_mid();
    wr(8'h04, 4'hF, 32'hFFFFFFFF, 0);
    wr(8'h18, 4'hF, 32'h33330000, 0);
    rdy = '0;
    wr(8'h10, 4'hF, 32'h00000001, 0);
    @(posedge clk) #1;
    fl = 2'b10;
    @(posedge clk) #1;
    fl = 2'b00;
    repeat (2) @(negedge clk);
    n_vec++;
    if (vld !== 2'b01 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset got vld=%b irq=%0b exp vld=01 irq=1", vld, irq);
    end
    @(posedge clk) #1;
    cyc = 1; stb = 1; we = 0; addr = 8'h04; sel = 4'hF; rst = 1;
    @(posedge clk) #1;
    cyc = 0; stb = 0;
    @(negedge clk);
    n_vec++;
    if ({ack, err, rdat, vld, irq} !== '0 || {word, cadr} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got ack=%0b err=%0b dat=%h vld=%b irq=%0b word=%h addr=%h exp all 0",
               ack, err, rdat, vld, irq, word, cadr);
    end
    @(posedge clk) #1;
    rst = 0;
    rd(8'h10, 32'h0, 0);
    rd(8'h14, 32'h0, 0);
    rd(8'h04, 32'h0, 0);
    rd(8'h20, 32'h0, 0);
    rd(8'h24, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_id();
    test_scratch();
    test_unmapped();
    test_nch4();
    test_cmd_handshake();
    test_cmd_busy();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/onfi_reg_bank.md
ONFI_REG_BANK -- requirements
Module: onfi_reg_bank

Interface
REQ-001 Parameter MM_DATA_W, 32, bus data width; only 32 is supported.
REQ-002 Parameter MM_ADDR_W, 8, byte address width; must be ≥ 8.
REQ-003 Parameter N_CH, 2, number of ONFI channels, 1..8.
REQ-004 Parameter ID_VALUE, 32'hdeaddead, value read at address 0x00.
REQ-005 mm_clk_i  in  1  single clock.
REQ-006 mm_rst_i  in  1  reset, synchronous, active-high.
REQ-007 mm_cyc_i, mm_stb_i  in  1 each  Wishbone cycle and strobe.
REQ-008 mm_we_i  in  1  write enable.
REQ-009 mm_addr_i  in  MM_ADDR_W  byte address, word aligned.
REQ-010 mm_sel_i  in  MM_DATA_W/8  byte lane selects.
REQ-011 mm_dat_i  in  MM_DATA_W  write data.
REQ-012 mm_dat_o  out  MM_DATA_W  read data.
REQ-013 mm_ack_o, mm_err_o  out  1 each  transfer termination.
REQ-014 cmd_valid_o  out  N_CH  per-channel command request.
REQ-015 cmd_ready_i  in  N_CH  per-channel command accept.
REQ-016 cmd_word_o, cmd_addr_o  out  32*N_CH each  channel c at bits [32c+31:32c].
REQ-017 done_i, fail_i  in  N_CH each  single-cycle completion/failure events.
REQ-018 irq_o  out  1  registered interrupt.

Function
REQ-019 Address map: 0x00 ID (RO); 0x04 SCRATCH (RW); per channel c, base B = 0x10 + 0x10*c: B+0 CMD (RW), B+4 STATUS (RO/W1C), B+8 ADDR (RW).
REQ-020 Bus FSM: IDLE -> RESP when mm_cyc_i & mm_stb_i; RESP -> IDLE unconditionally; ack or err asserted exactly one cycle, during RESP; minimum 2 cycles per transfer.
REQ-021 Request fields are sampled in IDLE; register writes commit on the IDLE->RESP edge; mm_dat_o is registered and valid during RESP, 0 otherwise.
REQ-022 Writes honour mm_sel_i per byte; a byte with sel = 0 keeps its value.
REQ-023 mm_err_o, with no state change, on any of: unmapped address, channel index ≥ N_CH, write to ID, write to CMD while that channel is busy.
REQ-024 Reads of unmapped addresses return 0 with err.
REQ-025 CMD bit0 GO: a write with GO = 1 (byte 0 selected) sets channel busy and cmd_valid_o[c] from the next cycle; the stored GO bit reads back 0.
REQ-026 cmd_valid_o[c] is held until a cycle with cmd_ready_i[c] = 1; it deasserts the following cycle and busy clears.
REQ-027 cmd_word_o/cmd_addr_o reflect the CMD/ADDR registers; both are stable while cmd_valid_o[c] = 1.
REQ-028 CMD bit1 IRQ_EN; CMD bits [31:2] are free command payload.
REQ-029 STATUS: bit0 DONE, bit1 FAIL (sticky, set by done_i/fail_i); bit31 BUSY (read-only); other bits read 0.
REQ-030 Writing 1 to STATUS bit0/bit1 clears it; if a set and a clear occur in the same cycle, the set wins.
REQ-031 irq_o is the registered OR over c of IRQ_EN[c] & (DONE[c] | FAIL[c]); latency 1 cycle after the status bit changes.
REQ-032 Deasserting mm_stb_i during RESP does not cancel the transfer: the write has already committed and ack is still driven.

Reset
REQ-033 With mm_rst_i = 1 at a clock edge: FSM = IDLE; all registers, busy, cmd_valid_o, irq_o, mm_ack_o, mm_err_o and mm_dat_o = 0.
REQ-034 Reset during a pending command drops cmd_valid_o the next cycle with no handshake; reset during RESP suppresses the ack.

Verification
REQ-035 Read 0x00 -> ack 1 cycle after stb, mm_dat_o = 32'hdeaddead; write 0x00 -> err, no ack.
REQ-036 Write 0x04 = 0xA5A5A5A5 with sel = 4'b0101, after SCRATCH = 0 -> readback 0x00A500A5.
REQ-037 Write CMD0 = 0x00000005, cmd_ready_i[0] low for 3 cycles then high -> cmd_valid_o[0] high for 4 cycles, cmd_word_o[31:0] = 0x00000004, STATUS0 bit31 = 1 throughout; a CMD0 write during this window -> err.
REQ-038 Set IRQ_EN on channel 1, pulse fail_i[1] -> STATUS1 = 0x2 and irq_o = 1; write STATUS1 = 0x2 -> bit cleared and irq_o = 0 one cycle later; done_i pulse coinciding with a W1C of bit0 -> DONE remains 1.
REQ-039 N_CH = 2, access 0x30 -> err, readback 0; with N_CH = 4 the same access -> ack.
REQ-040 Assert mm_rst_i mid-handshake -> all outputs 0 on the next cycle; CMD, STATUS and SCRATCH read 0.
